// File: rtl/twiddle_cmul.sv
`default_nettype none
// ============================================================================
// twiddle_cmul : 3-stage complex multiply of a DW-bit sample by a Q1.7 twiddle
// Revision     : 1.0
// ============================================================================
module twiddle_cmul #(
  parameter int DW    = 17,
  parameter int TW    = 8,
  parameter int SHIFT = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  input  logic [TW-1:0] tw_re,
  input  logic [TW-1:0] tw_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  input  logic          sat_clr,
  output logic          sat_flag
);

  localparam int PW = DW + TW;
  localparam int SW = PW + 1;

  logic                 en;

  logic                 v1_q;
  logic signed [DW-1:0] ar_q, ai_q;
  logic signed [TW-1:0] wr_q, wi_q;

  logic                 v2_q;
  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic signed [PW-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;

  logic signed [SW-1:0] w_sum_re, w_sum_im;
  logic signed [SW-1:0] w_shr_re, w_shr_im;
  logic [DW:0]          w_sat_re, w_sat_im;

  logic                 out_valid_q, out_valid_d;
  logic [DW-1:0]        out_re_q, out_re_d;
  logic [DW-1:0]        out_im_q, out_im_d;
  logic                 sat_flag_q, sat_flag_d;

  // One global enable: the whole pipe freezes while a result waits downstream.
  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;

  // Returns {saturated, clipped value}; the value fits when all bits above the
  // DW-bit field are copies of its sign bit.
  function automatic logic [DW:0] sat_fn(input logic signed [SW-1:0] v);
    logic [SW-DW:0] upper;
    upper = v[SW-1:DW-1];
    if ((&upper) | ~(|upper))
      sat_fn = {1'b0, v[DW-1:0]};
    else if (v[SW-1])
      sat_fn = {1'b1, 1'b1, {(DW-1){1'b0}}};
    else
      sat_fn = {1'b1, 1'b0, {(DW-1){1'b1}}};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else if (en) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
    end
  end

  // Data registers of empty stages are don't-care, so they carry no reset.
  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      ar_q <= in_re;
      ai_q <= in_im;
      wr_q <= tw_re;
      wi_q <= tw_im;
    end
  end

  assign w_p_rr = PW'(ar_q) * PW'(wr_q);
  assign w_p_ii = PW'(ai_q) * PW'(wi_q);
  assign w_p_ri = PW'(ar_q) * PW'(wi_q);
  assign w_p_ir = PW'(ai_q) * PW'(wr_q);

  always_ff @(posedge clk) begin
    if (en && v1_q) begin
      p_rr_q <= w_p_rr;
      p_ii_q <= w_p_ii;
      p_ri_q <= w_p_ri;
      p_ir_q <= w_p_ir;
    end
  end

  assign w_sum_re = SW'(p_rr_q) - SW'(p_ii_q);
  assign w_sum_im = SW'(p_ri_q) + SW'(p_ir_q);
  assign w_shr_re = w_sum_re >>> SHIFT;
  assign w_shr_im = w_sum_im >>> SHIFT;
  assign w_sat_re = sat_fn(w_shr_re);
  assign w_sat_im = sat_fn(w_shr_im);

  // Output data only moves with a real result; a set request beats a clear.
  always_comb begin
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    sat_flag_d  = sat_flag_q;
    if (sat_clr)
      sat_flag_d = 1'b0;
    if (en) begin
      out_valid_d = v2_q;
      if (v2_q) begin
        out_re_d = w_sat_re[DW-1:0];
        out_im_d = w_sat_im[DW-1:0];
        if (w_sat_re[DW] | w_sat_im[DW])
          sat_flag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      sat_flag_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign sat_flag  = sat_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_cmul.sv
`default_nettype none
// ============================================================================
// tb_twiddle_cmul : scoreboard bench for twiddle_cmul, directed vectors
// Revision        : 1.0
// ============================================================================
module tb_twiddle_cmul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_re, in_im;
  logic [7:0]  tw_re, tw_im;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_re, out_im;
  logic        sat_clr;
  logic        sat_flag;

  twiddle_cmul #(.DW(17), .TW(8), .SHIFT(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .tw_re     (tw_re),
    .tw_im     (tw_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .sat_clr   (sat_clr),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] re;
    logic [16:0] im;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Hand-computed vectors: ar, ai, wr, wi -> expected re, im.
  int dv_ar[12] = '{  4360,    256, 256, -65536,  65535, -1,  100, 1000, -3, 65535, -65536,      0};
  int dv_ai[12] = '{     0,   -256,   0, -65536,  65535,  0,    0, 2000,  5,     0,      0, -65536};
  int dv_wr[12] = '{   127,    127,   0,   -128,   -128,  1, -128,   64,  1,   127,   -128,      0};
  int dv_wi[12] = '{     0,      0, 127,   -128,   -128,  0,    0,   32,  1,     0,      0,   -128};
  int dv_er[12] = '{  4325,    254,   0,      0,      0, -1, -100,    0, -1, 65023,  65535, -65536};
  int dv_ei[12] = '{     0,   -254, 254,  65535, -65536,  0,    0, 1250,  0,     0,      0,      0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic send(input int ar, input int ai, input int wr, input int wi,
                      input int er, input int ei);
    int n;
    in_valid = 1'b1;
    in_re = ar[16:0];
    in_im = ai[16:0];
    tw_re = wr[7:0];
    tw_im = wi[7:0];
    #1;
    n = 0;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: in_ready stuck at %0b", in_ready);
    end else begin
      exp_q.push_back('{re: er[16:0], im: ei[16:0]});
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input int i);
    send(dv_ar[i], dv_ai[i], dv_wr[i], dv_wi[i], dv_er[i], dv_ei[i]);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!out_valid && n < 50);
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: out_valid=%0b after %0d cycles", out_valid, n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [16:0] model_comp(input longint s);
    longint t;
    t = s >>> 7;
    if (t > 65535)  return 17'h0FFFF;
    if (t < -65536) return 17'h10000;
    return t[16:0];
  endfunction

  // Monitor: pops the scoreboard on every output transfer, watches stalls.
  logic        hold_v = 1'b0;
  logic [16:0] hold_re, hold_im;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        hold_v = 1'b0;
      end else if (out_valid) begin
        if (hold_v) begin
          checks++;
          if (out_re !== hold_re || out_im !== hold_im) begin
            errors++;
            $display("FAIL stall_hold: got (%0h,%0h) held was (%0h,%0h)", out_re, out_im, hold_re, hold_im);
          end
        end
        if (out_ready) begin
          hold_v = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got (%0h,%0h) expected none", out_re, out_im);
          end else begin
            e = exp_q.pop_front();
            if (out_re !== e.re || out_im !== e.im) begin
              errors++;
              $display("FAIL result: got (%0h,%0h) expected (%0h,%0h)", out_re, out_im, e.re, e.im);
            end
          end
        end else begin
          hold_v  = 1'b1;
          hold_re = out_re;
          hold_im = out_im;
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_stall: got %0b expected 0", in_ready);
          end
        end
      end else begin
        if (hold_v) begin
          checks++;
          errors++;
          $display("FAIL valid_dropped: out_valid=%0b while stalled expected 1", out_valid);
        end
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    bit rnd_done;
    rst = 1'b1;
    in_valid = 1'b0;
    in_re = '0; in_im = '0; tw_re = '0; tw_im = '0;
    out_ready = 1'b1;
    sat_clr = 1'b0;

    repeat (3) step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_re",    32'(out_re),    32'd0);
    check("rst_out_im",    32'(out_im),    32'd0);
    check("rst_sat_flag",  32'(sat_flag),  32'd0);
    rst = 1'b0;
    step();
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Single sample: result visible exactly three cycles after transfer, for one cycle.
    send_vec(0);
    check("lat_c1_valid", 32'(out_valid), 32'd0);
    step();
    check("lat_c2_valid", 32'(out_valid), 32'd0);
    step();
    check("lat_c3_valid", 32'(out_valid), 32'd1);
    step();
    check("lat_c4_valid", 32'(out_valid), 32'd0);
    check("sat_flag_clean", 32'(sat_flag), 32'd0);

    send_vec(1);
    send_vec(2);
    for (int i = 5; i <= 9; i++) send_vec(i);
    drain();
    check("sat_flag_no_sat", 32'(sat_flag), 32'd0);

    // Saturation: set wins over a held clear, then the clear takes effect.
    sat_clr = 1'b1;
    send_vec(3);
    wait_out();
    check("sat_set_over_clr", 32'(sat_flag), 32'd1);
    step();
    check("sat_cleared_held", 32'(sat_flag), 32'd0);
    sat_clr = 1'b0;
    send_vec(10);
    wait_out();
    check("sat_set_pos_re", 32'(sat_flag), 32'd1);
    repeat (3) step();
    check("sat_sticky", 32'(sat_flag), 32'd1);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("sat_clr_pulse", 32'(sat_flag), 32'd0);

    // Back-to-back stream with a three-cycle downstream stall.
    fork
      begin
        for (int i = 4; i <= 11; i++) send_vec(i);
      end
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    check("sat_after_stream", 32'(sat_flag), 32'd1);

    // Reset with two samples in flight: nothing may emerge afterwards.
    send_vec(6);
    send_vec(7);
    rst = 1'b1;
    exp_q.delete();
    step();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_re",    32'(out_re),    32'd0);
    check("midrst_sat_flag",  32'(sat_flag),  32'd0);
    rst = 1'b0;
    step();
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (8) step();
    check("midrst_no_output", 32'(out_valid), 32'd0);

    // Random pairs with random gaps and backpressure against a local model.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          int ar, ai, wr, wi;
          ar = int'($urandom_range(0, 131071)) - 65536;
          ai = int'($urandom_range(0, 131071)) - 65536;
          wr = int'($urandom_range(0, 255)) - 128;
          wi = int'($urandom_range(0, 255)) - 128;
          if ($urandom_range(0, 7) == 0) ar = ($urandom_range(0, 1) == 1) ? 65535 : -65536;
          if ($urandom_range(0, 7) == 0) ai = ($urandom_range(0, 1) == 1) ? 65535 : -65536;
          if ($urandom_range(0, 3) == 0) step();
          send(ar, ai, wr, wi,
               int'(model_comp(longint'(ar) * wr - longint'(ai) * wi)),
               int'(model_comp(longint'(ar) * wi + longint'(ai) * wr)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
